// File: rtl/sprite_pixel_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sprite_pixel_fetch                                                |
// | Two-sprite ROM address generator and colour-keyed compositor, 2-cycle pipe |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sprite_pixel_fetch #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    COORD_W    = 10,
  parameter int                    SPR_W      = 32,
  parameter int                    SPR_H      = 32,
  parameter int                    FRAME_W    = 3,
  parameter logic [DATA_WIDTH-1:0] KEY        = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [COORD_W-1:0]    hcount,
  input  logic [COORD_W-1:0]    vcount,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [DATA_WIDTH-1:0] bg_pixel,
  input  logic                  s0_en_next,
  input  logic [COORD_W-1:0]    s0_x_next,
  input  logic [COORD_W-1:0]    s0_y_next,
  input  logic [FRAME_W-1:0]    s0_frm_next,
  input  logic                  s1_en_next,
  input  logic [COORD_W-1:0]    s1_x_next,
  input  logic [COORD_W-1:0]    s1_y_next,
  input  logic [FRAME_W-1:0]    s1_frm_next,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  video_on_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);

  localparam int CW = COORD_W + 1;

  // Active (frame-latched) sprite controls, index 0 = sprite 0
  logic                  en_q   [2];
  logic                  en_d   [2];
  logic [COORD_W-1:0]    x_q    [2];
  logic [COORD_W-1:0]    x_d    [2];
  logic [COORD_W-1:0]    y_q    [2];
  logic [COORD_W-1:0]    y_d    [2];
  logic [FRAME_W-1:0]    frm_q  [2];
  logic [FRAME_W-1:0]    frm_d  [2];

  logic                  w_en_next  [2];
  logic [COORD_W-1:0]    w_x_next   [2];
  logic [COORD_W-1:0]    w_y_next   [2];
  logic [FRAME_W-1:0]    w_frm_next [2];
  logic                  w_hit      [2];
  logic [ADDR_WIDTH-1:0] w_addr     [2];

  // Stage-1 and stage-2 pipeline registers
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [1:0]            hit1_q, hit1_d, hit2_q, hit2_d;
  logic [DATA_WIDTH-1:0] bg1_q, bg1_d, bg2_q, bg2_d;
  logic                  von1_q, von1_d, von2_q, von2_d;
  logic                  hs1_q, hs1_d, hs2_q, hs2_d;
  logic                  vs1_q, vs1_d, vs2_q, vs2_d;

  assign w_en_next[0]  = s0_en_next;
  assign w_x_next[0]   = s0_x_next;
  assign w_y_next[0]   = s0_y_next;
  assign w_frm_next[0] = s0_frm_next;
  assign w_en_next[1]  = s1_en_next;
  assign w_x_next[1]   = s1_x_next;
  assign w_y_next[1]   = s1_y_next;
  assign w_frm_next[1] = s1_frm_next;

  for (genvar s = 0; s < 2; s++) begin : g_spr
    logic [CW-1:0] hc_ext, vc_ext, x_ext, y_ext, dx, dy;

    always_comb begin
      en_d[s]  = en_q[s];
      x_d[s]   = x_q[s];
      y_d[s]   = y_q[s];
      frm_d[s] = frm_q[s];
      if (frame_start) begin
        en_d[s]  = w_en_next[s];
        x_d[s]   = w_x_next[s];
        y_d[s]   = w_y_next[s];
        frm_d[s] = w_frm_next[s];
      end
    end

    // One extra bit keeps the right/bottom bounds from wrapping at the raster edge
    always_comb begin
      hc_ext   = {1'b0, hcount};
      vc_ext   = {1'b0, vcount};
      x_ext    = {1'b0, x_q[s]};
      y_ext    = {1'b0, y_q[s]};
      dx       = hc_ext - x_ext;
      dy       = vc_ext - y_ext;
      w_hit[s] = en_q[s] & video_on
               & (hc_ext >= x_ext) & (hc_ext < x_ext + CW'(SPR_W))
               & (vc_ext >= y_ext) & (vc_ext < y_ext + CW'(SPR_H));
      w_addr[s] = '0;
      if (w_hit[s]) begin
        w_addr[s] = ADDR_WIDTH'(frm_q[s]) * ADDR_WIDTH'(SPR_W * SPR_H)
                  + ADDR_WIDTH'(dy) * ADDR_WIDTH'(SPR_W)
                  + ADDR_WIDTH'(dx);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        en_q[s]  <= 1'b0;
        x_q[s]   <= '0;
        y_q[s]   <= '0;
        frm_q[s] <= '0;
      end else begin
        en_q[s]  <= en_d[s];
        x_q[s]   <= x_d[s];
        y_q[s]   <= y_d[s];
        frm_q[s] <= frm_d[s];
      end
    end
  end

  always_comb begin
    addr_a_d = w_addr[0];
    addr_b_d = w_addr[1];
    hit1_d   = {w_hit[1], w_hit[0]};
    bg1_d    = bg_pixel;
    von1_d   = video_on;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
    hit2_d   = hit1_q;
    bg2_d    = bg1_q;
    von2_d   = von1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      hit1_q   <= '0;
      bg1_q    <= '0;
      von1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      hit2_q   <= '0;
      bg2_q    <= '0;
      von2_q   <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      hit1_q   <= hit1_d;
      bg1_q    <= bg1_d;
      von1_q   <= von1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      hit2_q   <= hit2_d;
      bg2_q    <= bg2_d;
      von2_q   <= von2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  // ROM data arrives in the same cycle as the stage-2 bits, so the final mux is combinational
  always_comb begin
    pix_out = bg2_q;
    if (hit2_q[1] && (q_b != KEY)) pix_out = q_b;
    if (hit2_q[0] && (q_a != KEY)) pix_out = q_a;
    if (!von2_q)                   pix_out = '0;
  end

  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign video_on_o = von2_q;
  assign hsync_o    = hs2_q;
  assign vsync_o    = vs2_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sprite_pixel_fetch                                             |
// | Directed vector bench for sprite_pixel_fetch                               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync_in, vsync_in;
  logic [15:0] bg_pixel;
  logic        s0_en_next, s1_en_next;
  logic [9:0]  s0_x_next, s0_y_next, s1_x_next, s1_y_next;
  logic [2:0]  s0_frm_next, s1_frm_next;
  logic [12:0] addr_a, addr_b;
  logic [15:0] q_a, q_b, pix_out;
  logic        video_on_o, hsync_o, vsync_o;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_pixel_fetch dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_pixel(bg_pixel),
    .s0_en_next(s0_en_next), .s0_x_next(s0_x_next), .s0_y_next(s0_y_next), .s0_frm_next(s0_frm_next),
    .s1_en_next(s1_en_next), .s1_x_next(s1_x_next), .s1_y_next(s1_y_next), .s1_frm_next(s1_frm_next),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .pix_out(pix_out), .video_on_o(video_on_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0_en, s0_x, s0_y, s0_frm;
    int s1_en, s1_x, s1_y, s1_frm;
    int hc, vc, von, hs, vs, bg, qa, qb;
    int ea, eb, epix;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hcount   = '0;
    vcount   = '0;
    video_on = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    bg_pixel = '0;
  endtask

  task automatic set_cfg(input int e0, input int x0, input int y0, input int f0,
                         input int e1, input int x1, input int y1, input int f1);
    s0_en_next  = 1'(e0);  s0_x_next = 10'(x0); s0_y_next = 10'(y0); s0_frm_next = 3'(f0);
    s1_en_next  = 1'(e1);  s1_x_next = 10'(x1); s1_y_next = 10'(y1); s1_frm_next = 3'(f1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    set_cfg(v.s0_en, v.s0_x, v.s0_y, v.s0_frm, v.s1_en, v.s1_x, v.s1_y, v.s1_frm);
    hcount   = 10'(v.hc);
    vcount   = 10'(v.vc);
    video_on = 1'(v.von);
    hsync_in = 1'(v.hs);
    vsync_in = 1'(v.vs);
    bg_pixel = 16'(v.bg);
    @(posedge clk); #1;
    check($sformatf("v%0d addr_a", idx), 32'(addr_a), v.ea);
    check($sformatf("v%0d addr_b", idx), 32'(addr_b), v.eb);
    idle_inputs();
    q_a = 16'(v.qa);
    q_b = 16'(v.qb);
    @(posedge clk); #1;
    check($sformatf("v%0d pix_out", idx), 32'(pix_out), v.epix);
    check($sformatf("v%0d video_on_o", idx), 32'(video_on_o), v.von);
    check($sformatf("v%0d hsync_o", idx), 32'(hsync_o), v.hs);
    check($sformatf("v%0d vsync_o", idx), 32'(vsync_o), v.vs);
  endtask

  task automatic pix_addr(input string name, input int hc, input int vc, input int exp_a);
    hcount   = 10'(hc);
    vcount   = 10'(vc);
    video_on = 1'b1;
    @(posedge clk); #1;
    check(name, 32'(addr_a), exp_a);
    idle_inputs();
  endtask

  initial begin
    //        s0: en  x     y     f   s1: en  x    y   f   hc    vc    von hs vs bg       qa       qb       ea    eb    epix
    vt[0]  = '{1, 100,  50,   0,  0,  0,   0,  0,  100,  50,   1,  1, 1, 'h1234, 'hABCD, 'h5555, 0,    0,    'hABCD};
    vt[1]  = '{1, 100,  50,   0,  0,  0,   0,  0,  131,  81,   1,  1, 1, 'h1234, 'h1111, 'h5555, 1023, 0,    'h1111};
    vt[2]  = '{1, 100,  50,   0,  0,  0,   0,  0,  132,  81,   1,  1, 1, 'h1234, 'h2222, 'h5555, 0,    0,    'h1234};
    vt[3]  = '{1, 100,  50,   2,  0,  0,   0,  0,  105,  51,   1,  1, 1, 'h1234, 'h3333, 'h5555, 2085, 0,    'h3333};
    vt[4]  = '{1, 100,  50,   0,  1,  110, 60, 1,  115,  65,   1,  1, 1, 'h00FF, 'h0000, 'hF800, 495,  1189, 'hF800};
    vt[5]  = '{1, 100,  50,   0,  1,  110, 60, 1,  115,  65,   1,  1, 1, 'h00FF, 'h07E0, 'hF800, 495,  1189, 'h07E0};
    vt[6]  = '{1, 100,  50,   0,  1,  110, 60, 1,  115,  65,   1,  1, 1, 'h00FF, 'h0000, 'h0000, 495,  1189, 'h00FF};
    vt[7]  = '{1, 100,  50,   0,  1,  110, 60, 1,  115,  65,   0,  0, 0, 'h00FF, 'h07E0, 'hF800, 0,    0,    'h0000};
    vt[8]  = '{1, 1020, 0,    0,  0,  0,   0,  0,  1023, 0,    1,  1, 1, 'h0BAD, 'h4444, 'h5555, 3,    0,    'h4444};
    vt[9]  = '{1, 1020, 0,    0,  0,  0,   0,  0,  0,    0,    1,  0, 1, 'h0BAD, 'h4444, 'h5555, 0,    0,    'h0BAD};
    vt[10] = '{1, 0,    0,    7,  0,  0,   0,  0,  31,   31,   1,  1, 0, 'h0001, 'h5A5A, 'h5555, 8191, 0,    'h5A5A};
    vt[11] = '{1, 0,    1000, 0,  0,  0,   0,  0,  0,    1023, 1,  1, 1, 'h0001, 'h6666, 'h5555, 736,  0,    'h6666};
    vt[12] = '{1, 100,  50,   0,  1,  100, 50, 1,  99,   50,   1,  1, 1, 'h0C0C, 'h7777, 'h8888, 0,    0,    'h0C0C};
    vt[13] = '{0, 100,  50,   0,  1,  100, 50, 3,  101,  52,   1,  1, 1, 'h0F0F, 'h7777, 'h0000, 0,    3137, 'h0F0F};

    reset       = 1'b1;
    frame_start = 1'b0;
    q_a         = '0;
    q_b         = '0;
    idle_inputs();
    s0_en_next = 1'b0; s0_x_next = '0; s0_y_next = '0; s0_frm_next = '0;
    s1_en_next = 1'b0; s1_x_next = '0; s1_y_next = '0; s1_frm_next = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pix_out", 32'(pix_out), 0);
    check("reset hsync_o", 32'(hsync_o), 1);
    check("reset vsync_o", 32'(vsync_o), 1);
    check("reset addr_a", 32'(addr_a), 0);
    check("reset addr_b", 32'(addr_b), 0);
    check("reset video_on_o", 32'(video_on_o), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Shadow controls stay invisible until frame_start
    set_cfg(1, 100, 50, 0, 0, 0, 0, 0);
    s0_x_next = 10'd200;
    pix_addr("shadow old pos", 105, 50, 5);
    pix_addr("shadow new pos ignored", 205, 50, 0);
    set_cfg(1, 200, 50, 0, 0, 0, 0, 0);
    pix_addr("latched new pos", 205, 50, 5);
    pix_addr("latched old pos gone", 105, 50, 0);

    // Reset mid-line discards in-flight pixels
    video_on = 1'b1;
    hsync_in = 1'b0;
    bg_pixel = 16'h1357;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stream video_on_o", 32'(video_on_o), 1);
    check("stream pix_out", 32'(pix_out), 'h1357);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset video_on_o", 32'(video_on_o), 0);
    check("midreset pix_out", 32'(pix_out), 0);
    check("midreset hsync_o", 32'(hsync_o), 1);
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    check("no replay video_on_o", 32'(video_on_o), 0);
    check("no replay hsync_o", 32'(hsync_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
